shift_seq: RTL and testbench

Parametrised sequenced shift engine. It generalises the team's single-step L2R shifter into a bidirectional, multi-mode shifter driven by a start/busy/done handshake. It performs a programmed number of 1-bit shifts, one per clock, and presents each bit shifted out as a serial stream. The block sits in the adder datapath to feed and drain serial adders and to do multi-position alignment shifts.

---
 rtl/shift_seq.sv | 153 +++++++++++++++
 tb/tb_shift_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Sequenced 1-bit-per-clock shift engine with a start/busy/done handshake.
// Supports logical, arithmetic, rotate and serial-in shifts in either direction.
module shift_seq #(
  parameter int DWIDTH = 8,
  parameter int SHW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] idata,
  input  logic              load,
  input  logic              start,
  input  logic              abort,
  input  logic [SHW-1:0]    shamt,
  input  logic              dir,
  input  logic [1:0]        mode,
  input  logic              fill_bit,
  input  logic              sin,
  output logic [DWIDTH-1:0] odata,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              done,
  output logic              dbg_state
);

  // Handshake: start is accepted only in IDLE (and only when load is low);
  // busy is high for exactly shamt cycles, done pulses one cycle after the
  // final shift, and abort ends a sequence early without a done pulse.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam logic [1:0] MODE_SIN = 2'b11;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              sout_q, sout_d;
  logic              sout_valid_q, sout_valid_d;
  logic              done_q, done_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic [1:0]        mode_q, mode_d;
  logic              fill_q, fill_d;

  logic              leave_bit;
  logic              fill_in;
  logic [DWIDTH-1:0] shifted;

  // One-step shift datapath, driven only by the configuration latched at start.
  always_comb begin
    leave_bit = dir_q ? data_q[DWIDTH-1] : data_q[0];
    fill_in   = 1'b0;
    case (mode_q)
      MODE_LOG: fill_in = fill_q;
      MODE_ARI: fill_in = dir_q ? 1'b0 : data_q[DWIDTH-1];
      MODE_ROT: fill_in = leave_bit;
      MODE_SIN: fill_in = sin;
      default:  fill_in = 1'b0;
    endcase
    if (dir_q) begin
      shifted = {data_q[DWIDTH-2:0], fill_in};
    end else begin
      shifted = {fill_in, data_q[DWIDTH-1:1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    fill_d       = fill_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = idata;
        end else if (start) begin
          if (shamt == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            dir_d   = dir;
            mode_d  = mode;
            fill_d  = fill_bit;
            cnt_d   = shamt;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          // Partial result is kept; the sequence simply stops here.
          cnt_d   = CNT_ZERO;
          state_d = IDLE;
        end else begin
          data_d       = shifted;
          sout_d       = leave_bit;
          sout_valid_d = 1'b1;
          cnt_d        = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      mode_q       <= MODE_LOG;
      fill_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      fill_q       <= fill_d;
    end
  end

  assign odata      = data_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = done_q;
  assign busy       = (state_q == SHIFT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: directed scenarios plus randomized sequences, checked
// cycle by cycle against an arithmetic model of the shift rules.
module tb_shift_seq;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  idata;
  logic          load, start, abort;
  logic [SW-1:0] shamt;
  logic          dir;
  logic [1:0]    mode;
  logic          fill_bit, sin;
  logic [W-1:0]  odata;
  logic          sout, sout_valid, busy, done, dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_data;
  logic         m_sout;

  shift_seq #(.DWIDTH(W), .SHW(SW)) dut (
    .clk(clk), .rst(rst), .idata(idata), .load(load), .start(start),
    .abort(abort), .shamt(shamt), .dir(dir), .mode(mode),
    .fill_bit(fill_bit), .sin(sin), .odata(odata), .sout(sout),
    .sout_valid(sout_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_valid, input logic e_busy,
                         input logic e_done);
    chk({tag, ".odata"}, 32'(odata), 32'(m_data));
    chk({tag, ".sout"}, 32'(sout), 32'(m_sout));
    chk({tag, ".sout_valid"}, 32'(sout_valid), 32'(e_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".state"}, 32'(dbg_state), 32'(e_busy));
  endtask

  // Reference: one 1-bit shift, stated directly from the mode/direction rules.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic d,
                                             input logic [1:0] md, input logic f,
                                             input logic s, output logic o);
    logic [W-1:0] r;
    logic         enter;
    o = d ? v[W-1] : v[0];
    case (md)
      2'd0:    enter = f;
      2'd1:    enter = d ? 1'b0 : v[W-1];
      2'd2:    enter = o;
      default: enter = s;
    endcase
    if (d) r = (v << 1) | (enter ? {{(W-1){1'b0}}, 1'b1} : '0);
    else   r = (v >> 1) | (enter ? MSB : '0);
    return r;
  endfunction

  task automatic load_reg(input logic [W-1:0] v);
    load = 1'b1;
    idata = v;
    step();
    load = 1'b0;
    m_data = v;
    chk_all("load", 1'b0, 1'b0, 1'b0);
  endtask

  // noise: 0 none, 1 load+start on the first shift cycle, 2 random ignored inputs
  task automatic do_seq(input int n, input logic d, input logic [1:0] md, input logic f,
                        input logic [15:0] sin_pat, input int abort_at, input int noise);
    logic o;
    start = 1'b1; shamt = SW'(n); dir = d; mode = md; fill_bit = f;
    step();
    start = 1'b0;
    if (n == 0) begin
      chk_all("zero", 1'b0, 1'b0, 1'b1);
      step();
      chk_all("zero_after", 1'b0, 1'b0, 1'b0);
      return;
    end
    chk_all("started", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= n; k++) begin
      sin = sin_pat[k-1];
      abort = (k == abort_at);
      if (noise == 1 && k == 1) begin
        load = 1'b1; idata = '0; start = 1'b1;
      end else if (noise == 2) begin
        load = 1'($urandom); start = 1'($urandom); idata = W'($urandom);
        mode = 2'($urandom); dir = 1'($urandom); fill_bit = 1'($urandom);
      end
      step();
      load = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        abort = 1'b0;
        chk_all("abort", 1'b0, 1'b0, 1'b0);
        step();
        chk_all("post_abort", 1'b0, 1'b0, 1'b0);
        return;
      end
      m_data = ref_shift(m_data, d, md, f, sin_pat[k-1], o);
      m_sout = o;
      chk_all("shift", 1'b1, k != n, k == n);
    end
    step();
    chk_all("idle", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; idata = '0; load = 1'b0; start = 1'b0; abort = 1'b0;
    shamt = '0; dir = 1'b0; mode = 2'b00; fill_bit = 1'b0; sin = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_data = '0;
    m_sout = 1'b0;
    chk_all("reset", 1'b0, 1'b0, 1'b0);

    // Logical L2R, fill 0
    load_reg(8'hB4);
    do_seq(3, 1'b0, 2'b00, 1'b0, 16'h0, 0, 0);
    chk("t1_final", 32'(odata), 32'h16);

    // Arithmetic both directions
    load_reg(8'h90);
    do_seq(2, 1'b0, 2'b01, 1'b0, 16'h0, 0, 0);
    chk("t2_l2r", 32'(odata), 32'hE4);
    load_reg(8'h90);
    do_seq(2, 1'b1, 2'b01, 1'b0, 16'h0, 0, 0);
    chk("t2_r2l", 32'(odata), 32'h40);

    // Rotate R2L wrapping past the register width
    load_reg(8'h81);
    do_seq(9, 1'b1, 2'b10, 1'b0, 16'h0, 0, 0);
    chk("t3_final", 32'(odata), 32'h03);

    // Serial-in, then zero-count start
    load_reg(8'h00);
    do_seq(4, 1'b1, 2'b11, 1'b0, 16'h000D, 0, 0);
    chk("t4_serial", 32'(odata), 32'h0B);
    do_seq(0, 1'b1, 2'b11, 1'b0, 16'h0, 0, 0);
    chk("t4_zero", 32'(odata), 32'h0B);

    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_all("idle_abort", 1'b0, 1'b0, 1'b0);

    // Abort with ignored load/start
    load_reg(8'hFF);
    do_seq(5, 1'b0, 2'b00, 1'b0, 16'h0, 3, 1);
    chk("t5_abort", 32'(odata), 32'h3F);

    // Saturation with logical fill 1
    load_reg(8'h00);
    do_seq(15, 1'b0, 2'b00, 1'b1, 16'h0, 0, 0);
    chk("sat_fill1", 32'(odata), 32'hFF);

    // Reset mid-sequence, then load/start collision
    load_reg(8'h55);
    start = 1'b1; shamt = 4'd6; dir = 1'b0; mode = 2'b10;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_data = '0;
    m_sout = 1'b0;
    chk_all("rst_mid", 1'b0, 1'b0, 1'b0);
    load = 1'b1; idata = 8'hA5; start = 1'b1; shamt = 4'd3;
    step();
    load = 1'b0; start = 1'b0;
    m_data = 8'hA5;
    chk_all("load_start", 1'b0, 1'b0, 1'b0);
    step();
    chk_all("load_start2", 1'b0, 1'b0, 1'b0);

    // Randomized sequences
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) load_reg(W'($urandom));
      do_seq($urandom_range(0, 15), 1'($urandom), 2'($urandom), 1'($urandom),
             16'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
